// File: rtl/internal_framebuffer_streamer.sv
// -----------------------------------------------------------------------------
// internal_framebuffer_streamer
//
// Reads a contiguous range of framebuffer RAM lines through the RAM read port
// and emits them as an AXI-Stream of memory-width beats. A 4-entry FIFO absorbs
// the RAM read latency. Reads are only issued while FIFO occupancy plus reads
// in flight stays below 4, so the FIFO can never overflow under backpressure.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            one-cycle request, sampled only while idle
//   confStartAddr    first RAM line of the transfer (latched on start)
//   confSize         number of beats to stream (latched on start, 0 = no-op)
//   busy             high from accepted start until done
//   done             one-cycle pulse when the transfer ends
//   readEnablePort   RAM read strobe (registered)
//   readAddrPort     RAM read address (registered)
//   readDataPort     RAM read data, READ_LATENCY cycles after the strobe
//   m_axis_*         AXI-Stream master (tvalid, tready, tlast, tdata)
// -----------------------------------------------------------------------------
module internal_framebuffer_streamer #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT    = 1,
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int READ_LATENCY                 = 1,
    localparam int MEM_WIDTH      = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - $clog2(NUMBER_OF_PIXELS_PER_BEAT)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] confStartAddr,
    input  logic [MEM_ADDR_WIDTH:0]   confSize,
    output logic                      busy,
    output logic                      done,
    output logic                      readEnablePort,
    output logic [MEM_ADDR_WIDTH-1:0] readAddrPort,
    input  logic [MEM_WIDTH-1:0]      readDataPort,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [MEM_WIDTH-1:0]      m_axis_tdata
);

    localparam int AW = MEM_ADDR_WIDTH;
    localparam int CW = MEM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t                  state_q,     state_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;
    logic                    rd_en_q,     rd_en_d;
    logic [AW-1:0]           rd_addr_q,   rd_addr_d;
    logic [CW-1:0]           size_q,      size_d;
    logic [CW-1:0]           issued_q,    issued_d;
    logic [CW-1:0]           sent_q,      sent_d;
    logic [READ_LATENCY-1:0] rd_vld_q,    rd_vld_d;
    logic [2:0]              in_flight_q, in_flight_d;
    logic [2:0]              fifo_cnt_q,  fifo_cnt_d;
    logic [1:0]              wr_ptr_q,    wr_ptr_d;
    logic [1:0]              rd_ptr_q,    rd_ptr_d;
    logic [MEM_WIDTH-1:0]    fifo_mem_q [4];
    logic [MEM_WIDTH-1:0]    fifo_mem_d [4];

    logic          fifo_wr;
    logic          tvalid;
    logic          pop;
    logic          last_beat;
    logic [3:0]    credit_used;
    logic          credit_ok;
    logic [CW-1:0] last_idx;

    // Read data lands in the FIFO exactly READ_LATENCY cycles after its strobe.
    assign fifo_wr   = rd_vld_q[READ_LATENCY-1];
    assign tvalid    = (fifo_cnt_q != 3'd0);
    assign pop       = tvalid && m_axis_tready;
    assign last_idx  = size_q - CW'(1);
    assign last_beat = (sent_q == last_idx);

    // A beat popped this cycle frees its slot for the read decided this cycle,
    // so the freed credit shows up as a strobe in the next cycle.
    assign credit_used = {1'b0, fifo_cnt_q} - {3'b000, pop} + {1'b0, in_flight_q};
    assign credit_ok   = (credit_used < 4'd4);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        size_d      = size_q;
        issued_d    = issued_q;
        sent_d      = sent_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_mem_d  = fifo_mem_q;

        rd_vld_d[0] = rd_en_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end

        if (fifo_wr) begin
            fifo_mem_d[wr_ptr_q] = readDataPort;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            sent_d   = sent_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (confSize != '0) begin
                        // First read goes out directly from the start edge.
                        state_d   = STREAM;
                        busy_d    = 1'b1;
                        size_d    = confSize;
                        issued_d  = CW'(1);
                        sent_d    = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = confStartAddr;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (issued_q == size_q) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    rd_en_d   = 1'b1;
                    // Address wraps modulo the RAM depth.
                    rd_addr_d = rd_addr_q + AW'(1);
                    issued_d  = issued_q + CW'(1);
                    if (issued_d == size_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Handshake of the final beat ends the transfer.
        if (busy_q && pop && last_beat) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        fifo_cnt_d  = fifo_cnt_q + {2'b00, fifo_wr} - {2'b00, pop};
        in_flight_d = in_flight_q + {2'b00, rd_en_d} - {2'b00, fifo_wr};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            size_q      <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            rd_vld_q    <= '0;
            in_flight_q <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            size_q      <= size_d;
            issued_q    <= issued_d;
            sent_q      <= sent_d;
            rd_vld_q    <= rd_vld_d;
            in_flight_q <= in_flight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_mem_q  <= fifo_mem_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign readEnablePort = rd_en_q;
    assign readAddrPort   = rd_addr_q;
    assign m_axis_tvalid  = tvalid;
    assign m_axis_tlast   = tvalid && last_beat;
    assign m_axis_tdata   = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_internal_framebuffer_streamer.sv
// -----------------------------------------------------------------------------
// Bench for internal_framebuffer_streamer. Two instances: A uses the default
// parameters (latency 1, 1 pixel per beat, 18-bit line address), B uses
// latency 2 with 2 pixels per beat. RAM models return a known function of the
// line address. Stimulus pushes expected reads/beats into queues; monitors pop
// and compare whenever the DUT strobes a read or completes a handshake.
// -----------------------------------------------------------------------------
module tb_internal_framebuffer_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic        a_resetn = 1'b0;
    logic        a_start = 1'b0;
    logic [17:0] a_cfg_addr = '0;
    logic [18:0] a_cfg_size = '0;
    logic        a_busy, a_done, a_ren, a_tvalid, a_tlast;
    logic        a_tready = 1'b0;
    logic [17:0] a_raddr;
    logic [31:0] a_rdata = '0;
    logic [31:0] a_tdata;
    int          a_mode = 0;

    internal_framebuffer_streamer u_a (
        .clk(clk), .resetn(a_resetn), .start(a_start),
        .confStartAddr(a_cfg_addr), .confSize(a_cfg_size),
        .busy(a_busy), .done(a_done),
        .readEnablePort(a_ren), .readAddrPort(a_raddr), .readDataPort(a_rdata),
        .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
        .m_axis_tlast(a_tlast), .m_axis_tdata(a_tdata)
    );

    // RAM line k holds k.
    always @(posedge clk) if (a_ren) a_rdata <= 32'(a_raddr);

    // tready: 0 = always high, 1 = always low, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (a_mode)
                0:       a_tready = 1'b1;
                1:       a_tready = 1'b0;
                default: a_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_a_t;

    beat_a_t     a_exp_q[$];
    logic [17:0] a_addr_q[$];
    int a_outst = 0, a_rd_cnt = 0, a_hs_cnt = 0, a_tv_cnt = 0, a_done_cnt = 0;
    bit a_done_exp = 0, a_stall_prev = 0, a_prev_last = 0;
    logic [31:0] a_prev_data = '0;

    always @(negedge clk) begin
        if (!a_resetn) begin
            a_outst      = 0;
            a_done_exp   = 0;
            a_stall_prev = 0;
        end else begin
            beat_a_t     e;
            logic [17:0] ea;
            if (a_done_exp) check("a_done_after_last", 64'(a_done), 64'd1);
            if (a_done) a_done_cnt++;
            if (a_stall_prev)
                check("a_axis_hold", 64'({a_tvalid, a_tlast, a_tdata}), 64'({1'b1, a_prev_last, a_prev_data}));
            if (a_ren) begin
                a_rd_cnt++;
                a_outst++;
                check("a_outstanding_le4", 64'(a_outst <= 4), 64'd1);
                check("a_read_expected", 64'(a_addr_q.size() != 0), 64'd1);
                if (a_addr_q.size() != 0) begin
                    ea = a_addr_q.pop_front();
                    check("a_read_addr", 64'(a_raddr), 64'(ea));
                end
            end
            if (a_tvalid) a_tv_cnt++;
            if (a_tvalid && a_tready) begin
                a_outst--;
                a_hs_cnt++;
                check("a_beat_expected", 64'(a_exp_q.size() != 0), 64'd1);
                if (a_exp_q.size() != 0) begin
                    e = a_exp_q.pop_front();
                    check("a_beat_data", 64'(a_tdata), 64'(e.data));
                    check("a_beat_last", 64'(a_tlast), 64'(e.last));
                end
            end
            a_done_exp   = a_tvalid && a_tready && a_tlast;
            a_stall_prev = a_tvalid && !a_tready;
            a_prev_data  = a_tdata;
            a_prev_last  = a_tlast;
        end
    end

    task automatic a_issue(input logic [17:0] addr, input int size);
        for (int i = 0; i < size; i++) begin
            logic [17:0] ad;
            ad = addr + 18'(i);
            a_addr_q.push_back(ad);
            a_exp_q.push_back({32'(ad), (i == size - 1)});
        end
        @(negedge clk);
        a_cfg_addr = addr;
        a_cfg_size = 19'(size);
        a_start    = 1'b1;
        @(negedge clk);
        a_start    = 1'b0;
        a_cfg_addr = 18'h2AAAA;
        a_cfg_size = 19'd7;
    endtask

    task automatic a_wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!a_busy && !a_tvalid && a_exp_q.size() == 0 && a_addr_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        check(name, 64'(ok), 64'd1);
    endtask

    // ---------------- instance B ----------------
    logic        b_start = 1'b0;
    logic [16:0] b_cfg_addr = '0;
    logic [17:0] b_cfg_size = '0;
    logic        b_busy, b_done, b_ren, b_tvalid, b_tlast;
    logic        b_tready = 1'b1;
    logic [16:0] b_raddr;
    logic [63:0] b_pipe = '0;
    logic [63:0] b_rdata = '0;
    logic [63:0] b_tdata;

    internal_framebuffer_streamer #(
        .NUMBER_OF_PIXELS_PER_BEAT(2),
        .READ_LATENCY(2)
    ) u_b (
        .clk(clk), .resetn(a_resetn), .start(b_start),
        .confStartAddr(b_cfg_addr), .confSize(b_cfg_size),
        .busy(b_busy), .done(b_done),
        .readEnablePort(b_ren), .readAddrPort(b_raddr), .readDataPort(b_rdata),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
        .m_axis_tlast(b_tlast), .m_axis_tdata(b_tdata)
    );

    function automatic logic [63:0] b_line(input logic [16:0] k);
        return {32'h1000_0000 + 32'(k), 32'(k)};
    endfunction

    // Two-stage RAM: strobe in cycle c, data valid in cycle c+2.
    always @(posedge clk) begin
        if (b_ren) b_pipe <= b_line(b_raddr);
        b_rdata <= b_pipe;
    end

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_b_t;

    beat_b_t b_exp_q[$];
    int b_done_cnt = 0;
    bit b_done_exp = 0;

    always @(negedge clk) begin
        if (a_resetn) begin
            beat_b_t e;
            if (b_done_exp) check("b_done_after_last", 64'(b_done), 64'd1);
            if (b_done) b_done_cnt++;
            if (b_tvalid && b_tready) begin
                check("b_beat_expected", 64'(b_exp_q.size() != 0), 64'd1);
                if (b_exp_q.size() != 0) begin
                    e = b_exp_q.pop_front();
                    check("b_beat_data", b_tdata, e.data);
                    check("b_beat_last", 64'(b_tlast), 64'(e.last));
                end
            end
            b_done_exp = b_tvalid && b_tready && b_tlast;
        end else begin
            b_done_exp = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat, span, d0, r0, t0, h0;
        bit ok;

        repeat (3) @(negedge clk);
        check("a_reset_outputs",
              64'({a_busy, a_done, a_ren, a_raddr, a_tvalid, a_tlast, a_tdata}), 64'd0);
        check("b_reset_outputs", 64'({b_busy, b_done, b_ren, b_raddr, b_tvalid, b_tlast}), 64'd0);
        a_resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic: 8 beats from line 0, tready high.
        d0 = a_done_cnt;
        a_issue(18'd0, 8);
        check("a_basic_busy_c1", 64'(a_busy), 64'd1);
        check("a_basic_ren_c1", 64'(a_ren), 64'd1);
        check("a_basic_addr_c1", 64'(a_raddr), 64'd0);
        lat = 1;
        while (!a_tvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("a_basic_first_tvalid_cycle", 64'(lat), 64'd3);
        span = 0;
        for (int j = 0; j < 200; j++) begin
            span++;
            if (a_tvalid && a_tready && a_tlast) break;
            @(negedge clk);
        end
        check("a_basic_beat_span", 64'(span), 64'd8);
        a_wait_idle("a_basic_idle");
        check("a_basic_done_count", 64'(a_done_cnt - d0), 64'd1);

        // Wrap past the top line.
        a_issue(18'h3FFFE, 4);
        a_wait_idle("a_wrap_idle");

        // Backpressure: tready low for 20 cycles.
        a_mode = 1;
        repeat (2) @(negedge clk);
        h0 = a_hs_cnt;
        a_issue(18'd100, 16);
        repeat (20) @(negedge clk);
        check("a_bp_outstanding", 64'(a_outst), 64'd4);
        check("a_bp_read_stalled", 64'(a_ren), 64'd0);
        check("a_bp_tvalid_held", 64'(a_tvalid), 64'd1);
        a_mode = 0;
        a_wait_idle("a_bp_idle");
        check("a_bp_beats", 64'(a_hs_cnt - h0), 64'd16);

        // Random tready.
        a_mode = 2;
        h0 = a_hs_cnt;
        a_issue(18'd200, 16);
        a_wait_idle("a_rand_idle");
        check("a_rand_beats", 64'(a_hs_cnt - h0), 64'd16);
        a_mode = 0;
        repeat (2) @(negedge clk);

        // Zero size.
        d0 = a_done_cnt; r0 = a_rd_cnt; t0 = a_tv_cnt;
        @(negedge clk);
        a_cfg_addr = 18'd5;
        a_cfg_size = 19'd0;
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("a_zero_done", 64'(a_done), 64'd1);
        check("a_zero_busy", 64'(a_busy), 64'd0);
        repeat (5) @(negedge clk);
        check("a_zero_reads", 64'(a_rd_cnt - r0), 64'd0);
        check("a_zero_tvalid", 64'(a_tv_cnt - t0), 64'd0);
        check("a_zero_done_count", 64'(a_done_cnt - d0), 64'd1);

        // Start while busy is ignored.
        d0 = a_done_cnt; h0 = a_hs_cnt; r0 = a_rd_cnt;
        a_issue(18'd300, 10);
        repeat (2) @(negedge clk);
        a_cfg_addr = 18'd500;
        a_cfg_size = 19'd5;
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_wait_idle("a_ignore_idle");
        check("a_ignore_done_count", 64'(a_done_cnt - d0), 64'd1);
        check("a_ignore_beats", 64'(a_hs_cnt - h0), 64'd10);
        check("a_ignore_reads", 64'(a_rd_cnt - r0), 64'd10);

        // Reset mid-stream.
        h0 = a_hs_cnt;
        a_issue(18'd50, 10);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (a_hs_cnt - h0 >= 5) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("a_midreset_reached", 64'(ok), 64'd1);
        @(posedge clk);
        #2;
        a_resetn = 1'b0;
        #1;
        check("a_midreset_outputs",
              64'({a_busy, a_done, a_ren, a_raddr, a_tvalid, a_tlast, a_tdata}), 64'd0);
        a_exp_q.delete();
        a_addr_q.delete();
        b_exp_q.delete();
        repeat (2) @(negedge clk);
        a_resetn = 1'b1;
        repeat (2) @(negedge clk);
        h0 = a_hs_cnt;
        a_issue(18'd0, 3);
        a_wait_idle("a_after_reset_idle");
        check("a_after_reset_beats", 64'(a_hs_cnt - h0), 64'd3);

        // Instance B: latency 2, 2 pixels/beat, 32 beats at full rate.
        for (int i = 0; i < 32; i++) begin
            b_exp_q.push_back({b_line(17'(i)), (i == 31)});
        end
        d0 = b_done_cnt;
        @(negedge clk);
        b_cfg_addr = 17'd0;
        b_cfg_size = 18'd32;
        b_start    = 1'b1;
        @(negedge clk);
        b_start    = 1'b0;
        b_cfg_size = 18'd3;
        lat = 1;
        while (!b_tvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("b_first_tvalid_cycle", 64'(lat), 64'd4);
        span = 0;
        for (int j = 0; j < 200; j++) begin
            span++;
            if (b_tvalid && b_tready && b_tlast) break;
            @(negedge clk);
        end
        check("b_beat_span", 64'(span), 64'd32);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!b_busy && !b_tvalid && b_exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        check("b_idle", 64'(ok), 64'd1);
        check("b_done_count", 64'(b_done_cnt - d0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
